// File: rtl/fnn_pkg.sv
// Shared definitions for the fully connected layer blocks.
package fnn_pkg;

    localparam int WEIGHT_WIDTH   = 16;
    localparam int NUM_WEIGHT_DEF = 30;
    localparam int NUM_NEURON_DEF = 10;

    typedef logic signed [WEIGHT_WIDTH-1:0] weight_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        READY  = 2'd1,
        STREAM = 2'd2
    } wm_state_e;

endpackage

// File: rtl/weight_ram_1r1w.sv
// Single-channel simple dual-port weight RAM with registered read.
module weight_ram_1r1w #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 30,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic        [ADDR_WIDTH-1:0] waddr,
    input  logic signed [DATA_WIDTH-1:0] wdata,
    input  logic                         re,
    input  logic        [ADDR_WIDTH-1:0] raddr,
    output logic signed [DATA_WIDTH-1:0] rdata
);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: storage is never reset, only overwritten by a load.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: output register only changes when a read is issued, so it holds during stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/weight_mem_stream.sv
// Loadable weight bank for one FC layer; loads neuron-major, replays all channels in lock-step.
module weight_mem_stream
    import fnn_pkg::*;
#(
    parameter int NUM_WEIGHT = NUM_WEIGHT_DEF,
    parameter int NUM_NEURON = NUM_NEURON_DEF,
    parameter int DATA_WIDTH = WEIGHT_WIDTH,
    parameter int ADDR_WIDTH = $clog2(NUM_WEIGHT),
    parameter int NID_WIDTH  = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load_clear,
    input  logic                             load_valid,
    input  logic [DATA_WIDTH-1:0]            load_data,
    output logic                             load_ready,
    output logic                             loaded,
    input  logic                             stream_start,
    input  logic                             stream_stall,
    output logic [NUM_NEURON*DATA_WIDTH-1:0] w_out,
    output logic                             w_valid,
    output logic [ADDR_WIDTH-1:0]            w_addr,
    output logic                             w_first,
    output logic                             w_last,
    output logic                             busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHT - 1);
    localparam logic [NID_WIDTH-1:0]  LAST_NID  = NID_WIDTH'(NUM_NEURON - 1);

    wm_state_e             state;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [NID_WIDTH-1:0]  wr_nid;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_fire;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_next;

    assign w_addr = rd_addr;

    // Decide this cycle's RAM write and read; clear and reset suppress both.
    always_comb begin
        wr_fire = 1'b0;
        rd_en   = 1'b0;
        rd_next = '0;
        if (!rst && !load_clear) begin
            case (state)
                EMPTY:  wr_fire = load_valid;
                READY:  rd_en   = stream_start;
                STREAM: begin
                    if (!stream_stall) begin
                        if (rd_addr == LAST_ADDR) begin
                            rd_en = stream_start;
                        end else begin
                            rd_en   = 1'b1;
                            rd_next = rd_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    genvar n;
    generate
        for (n = 0; n < NUM_NEURON; n++) begin : g_chan
            logic signed [DATA_WIDTH-1:0] rdata;

            weight_ram_1r1w #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (NUM_WEIGHT),
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_ram (
                .clk   (clk),
                .rst   (rst),
                .we    (wr_fire && (wr_nid == NID_WIDTH'(n))),
                .waddr (wr_addr),
                .wdata (load_data),
                .re    (rd_en),
                .raddr (rd_next),
                .rdata (rdata)
            );

            assign w_out[n*DATA_WIDTH +: DATA_WIDTH] = rdata;
        end
    endgenerate

    // Control FSM: write counters, read counter and the registered stream markers.
    always_ff @(posedge clk) begin
        if (rst || load_clear) begin
            state      <= EMPTY;
            load_ready <= 1'b1;
            loaded     <= 1'b0;
            w_valid    <= 1'b0;
            w_first    <= 1'b0;
            w_last     <= 1'b0;
            busy       <= 1'b0;
            rd_addr    <= '0;
            wr_addr    <= '0;
            wr_nid     <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (load_valid) begin
                        if (wr_addr == LAST_ADDR) begin
                            wr_addr <= '0;
                            if (wr_nid == LAST_NID) begin
                                wr_nid     <= '0;
                                state      <= READY;
                                loaded     <= 1'b1;
                                load_ready <= 1'b0;
                            end else begin
                                wr_nid <= wr_nid + NID_WIDTH'(1);
                            end
                        end else begin
                            wr_addr <= wr_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                READY: begin
                    if (stream_start) begin
                        state   <= STREAM;
                        busy    <= 1'b1;
                        w_valid <= 1'b1;
                        rd_addr <= '0;
                        w_first <= 1'b1;
                        w_last  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (!stream_stall) begin
                        if (rd_addr == LAST_ADDR) begin
                            if (stream_start) begin
                                rd_addr <= '0;
                                w_first <= 1'b1;
                                w_last  <= 1'b0;
                            end else begin
                                state   <= READY;
                                busy    <= 1'b0;
                                w_valid <= 1'b0;
                                w_first <= 1'b0;
                                w_last  <= 1'b0;
                            end
                        end else begin
                            rd_addr <= rd_next;
                            w_first <= 1'b0;
                            w_last  <= (rd_next == LAST_ADDR);
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_mem_stream.sv
// Directed bench for weight_mem_stream with a 2-neuron x 4-weight bank.
module tb_weight_mem_stream;

    localparam int NW = 4;
    localparam int NN = 2;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_clear = 1'b0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_ready;
    logic          loaded;
    logic          stream_start = 1'b0;
    logic          stream_stall = 1'b0;
    logic [NN*DW-1:0] w_out;
    logic          w_valid;
    logic [1:0]    w_addr;
    logic          w_first;
    logic          w_last;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    weight_mem_stream #(
        .NUM_WEIGHT (NW),
        .NUM_NEURON (NN),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_clear   (load_clear),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .loaded       (loaded),
        .stream_start (stream_start),
        .stream_stall (stream_stall),
        .w_out        (w_out),
        .w_valid      (w_valid),
        .w_addr       (w_addr),
        .w_first      (w_first),
        .w_last       (w_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        stall;
        logic        valid;
        logic [1:0]  addr;
        logic        first;
        logic        last;
        logic        bsy;
        logic [31:0] wout;
        logic        chk_data;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected vector at weight index a for a load starting at base: {ch1, ch0}.
    function automatic logic [31:0] vexp(input logic [15:0] base, input int a);
        logic [15:0] c0, c1;
        c0 = base + 16'(a);
        c1 = base + 16'(a + NW);
        return {c1, c0};
    endfunction

    task automatic add(input logic st, input logic sl, input logic v, input int a,
                       input logic f, input logic l, input logic b,
                       input logic [31:0] wo, input logic cd);
        vec_t e;
        e.start = st; e.stall = sl; e.valid = v; e.addr = 2'(a);
        e.first = f; e.last = l; e.bsy = b; e.wout = wo; e.chk_data = cd;
        tbl.push_back(e);
    endtask

    task automatic run_tbl(input string tag);
        foreach (tbl[i]) begin
            stream_start = tbl[i].start;
            stream_stall = tbl[i].stall;
            @(negedge clk);
            chk({tag, ".w_valid"}, 32'(w_valid), 32'(tbl[i].valid));
            chk({tag, ".busy"}, 32'(busy), 32'(tbl[i].bsy));
            if (tbl[i].chk_data) begin
                chk({tag, ".w_addr"}, 32'(w_addr), 32'(tbl[i].addr));
                chk({tag, ".w_first"}, 32'(w_first), 32'(tbl[i].first));
                chk({tag, ".w_last"}, 32'(w_last), 32'(tbl[i].last));
                chk({tag, ".w_out"}, w_out, tbl[i].wout);
            end
        end
        stream_start = 1'b0;
        stream_stall = 1'b0;
        tbl.delete();
    endtask

    task automatic load_all(input logic [15:0] base, input bit gaps, input string tag);
        for (int k = 0; k < NN * NW; k++) begin
            if (gaps) begin
                load_valid = 1'b0;
                load_data  = 16'hDEAD;
                @(negedge clk);
            end
            load_valid = 1'b1;
            load_data  = base + 16'(k);
            chk({tag, ".load_ready"}, 32'(load_ready), 32'd1);
            @(negedge clk);
            if (k < NN * NW - 1) chk({tag, ".loaded_early"}, 32'(loaded), 32'd0);
        end
        load_valid = 1'b0;
        load_data  = '0;
        chk({tag, ".loaded"}, 32'(loaded), 32'd1);
        chk({tag, ".load_ready_low"}, 32'(load_ready), 32'd0);
    endtask

    // One plain pass over a bank loaded from base.
    task automatic plain_stream(input logic [15:0] base, input string tag);
        add(1, 0, 1, 0, 1, 0, 1, vexp(base, 0), 1);
        add(0, 0, 1, 1, 0, 0, 1, vexp(base, 1), 1);
        add(0, 0, 1, 2, 0, 0, 1, vexp(base, 2), 1);
        add(0, 0, 1, 3, 0, 1, 1, vexp(base, 3), 1);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        run_tbl(tag);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst.load_ready", 32'(load_ready), 32'd1);
        chk("rst.loaded", 32'(loaded), 32'd0);
        chk("rst.w_valid", 32'(w_valid), 32'd0);
        chk("rst.w_first", 32'(w_first), 32'd0);
        chk("rst.w_last", 32'(w_last), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.w_addr", 32'(w_addr), 32'd0);
        chk("rst.w_out", w_out, 32'h0);

        // Gapless load and a plain stream
        load_all(16'h0001, 1'b0, "load1");
        plain_stream(16'h0001, "stream1");
        chk("stream1.loaded_kept", 32'(loaded), 32'd1);

        // Clear from READY, gapped reload, identical stream
        load_clear = 1'b1;
        @(negedge clk);
        load_clear = 1'b0;
        chk("clr_ready.loaded", 32'(loaded), 32'd0);
        chk("clr_ready.load_ready", 32'(load_ready), 32'd1);
        load_all(16'h0001, 1'b1, "load_gap");
        plain_stream(16'h0001, "stream_gap");

        // Stall for three cycles at address 1
        add(1, 0, 1, 0, 1, 0, 1, vexp(16'h0001, 0), 1);
        add(0, 0, 1, 1, 0, 0, 1, vexp(16'h0001, 1), 1);
        add(0, 1, 1, 1, 0, 0, 1, 32'h0006_0002, 1);
        add(0, 1, 1, 1, 0, 0, 1, 32'h0006_0002, 1);
        add(0, 1, 1, 1, 0, 0, 1, 32'h0006_0002, 1);
        add(0, 0, 1, 2, 0, 0, 1, vexp(16'h0001, 2), 1);
        add(0, 0, 1, 3, 0, 1, 1, vexp(16'h0001, 3), 1);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        run_tbl("stall");

        // Start held through w_last: back-to-back passes, then READY
        add(1, 0, 1, 0, 1, 0, 1, 32'h0005_0001, 1);
        add(1, 0, 1, 1, 0, 0, 1, 32'h0006_0002, 1);
        add(1, 0, 1, 2, 0, 0, 1, 32'h0007_0003, 1);
        add(1, 0, 1, 3, 0, 1, 1, 32'h0008_0004, 1);
        add(1, 0, 1, 0, 1, 0, 1, 32'h0005_0001, 1);
        add(0, 0, 1, 1, 0, 0, 1, 32'h0006_0002, 1);
        add(0, 0, 1, 2, 0, 0, 1, 32'h0007_0003, 1);
        add(0, 0, 1, 3, 0, 1, 1, 32'h0008_0004, 1);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        run_tbl("restart");
        chk("restart.load_ready", 32'(load_ready), 32'd0);

        // load_clear mid-stream at w_addr=2
        add(1, 0, 1, 0, 1, 0, 1, 32'h0005_0001, 1);
        add(0, 0, 1, 1, 0, 0, 1, 32'h0006_0002, 1);
        add(0, 0, 1, 2, 0, 0, 1, 32'h0007_0003, 1);
        run_tbl("pre_clr");
        load_clear = 1'b1;
        @(negedge clk);
        load_clear = 1'b0;
        chk("clr_stream.w_valid", 32'(w_valid), 32'd0);
        chk("clr_stream.loaded", 32'(loaded), 32'd0);
        chk("clr_stream.load_ready", 32'(load_ready), 32'd1);
        chk("clr_stream.busy", 32'(busy), 32'd0);
        load_all(16'hFFF0, 1'b0, "load_neg");
        add(1, 0, 1, 0, 1, 0, 1, 32'hFFF4_FFF0, 1);
        add(0, 0, 1, 1, 0, 0, 1, 32'hFFF5_FFF1, 1);
        add(0, 0, 1, 2, 0, 0, 1, 32'hFFF6_FFF2, 1);
        add(0, 0, 1, 3, 0, 1, 1, 32'hFFF7_FFF3, 1);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        run_tbl("stream_neg");

        // Reset after 5 of 8 beats, start while EMPTY, clear beating a valid beat
        load_clear = 1'b1;
        @(negedge clk);
        load_clear = 1'b0;
        for (int k = 0; k < 5; k++) begin
            load_valid = 1'b1;
            load_data  = 16'h0A00 + 16'(k);
            @(negedge clk);
        end
        load_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.loaded", 32'(loaded), 32'd0);
        chk("rst_mid.load_ready", 32'(load_ready), 32'd1);
        chk("rst_mid.w_out", w_out, 32'h0);
        stream_start = 1'b1;
        @(negedge clk);
        stream_start = 1'b0;
        chk("empty_start.w_valid", 32'(w_valid), 32'd0);
        chk("empty_start.busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("empty_start.w_valid2", 32'(w_valid), 32'd0);
        load_clear = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'h0BAD;
        @(negedge clk);
        load_clear = 1'b0;
        load_valid = 1'b0;
        chk("clr_beat.loaded", 32'(loaded), 32'd0);
        load_all(16'h0100, 1'b0, "load_after_rst");
        plain_stream(16'h0100, "stream_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/weight_mem_stream.md
Name: weight_mem_stream

Overview:
- Parametrised, loadable weight memory for one fully connected layer: NUM_NEURON channels, each holding NUM_WEIGHT signed fixed-point weights.
- Replaces per-neuron hard-coded weight ROMs with a single bank.
- Weights are loaded once through a valid/ready stream, then replayed to all neurons in lock-step, one address per cycle.
- Each replay supports stall and produces first/last markers for the neuron MAC pipelines.

Parameters:
- NUM_WEIGHT, 30: weights per neuron (layer input count); must be >= 2.
- NUM_NEURON, 10: neurons/channels served in parallel; must be >= 1.
- DATA_WIDTH, 16: weight width, two's complement fixed point.
- ADDR_WIDTH, $clog2(NUM_WEIGHT): weight index width.
- NID_WIDTH, $clog2(NUM_NEURON) (minimum 1): neuron index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- load_clear  in  1  discard loaded weights and return to EMPTY.
- load_valid  in  1  load beat present.
- load_data  in  DATA_WIDTH  load beat payload.
- load_ready  out  1  bank accepts load beats.
- loaded  out  1  all NUM_NEURON*NUM_WEIGHT weights written.
- stream_start  in  1  request one replay pass.
- stream_stall  in  1  hold the output stream.
- w_out  out  NUM_NEURON*DATA_WIDTH  channel n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
- w_valid  out  1  w_out holds a valid weight vector.
- w_addr  out  ADDR_WIDTH  weight index of the current w_out.
- w_first  out  1  w_valid and w_addr==0.
- w_last  out  1  w_valid and w_addr==NUM_WEIGHT-1.
- busy  out  1  state is STREAM.

Behaviour:
- Clock and reset: one clock domain. rst is synchronous, active-high.
- Reset values: state=EMPTY, load_ready=1, loaded=0, w_valid=0, w_first=0, w_last=0, busy=0, w_addr=0, w_out=0, counters=0. Memory array has no reset; contents are undefined until loaded.
- FSM states: EMPTY, READY, STREAM.
- EMPTY:
  - load_ready=1. A beat is accepted when load_valid && load_ready.
  - Accepted beats are written neuron-major: beat k goes to neuron k/NUM_WEIGHT, address k%NUM_WEIGHT.
  - The write counters are a nid counter and an addr counter; addr wraps at NUM_WEIGHT-1 and increments nid.
  - On accepting the final beat (nid=NUM_NEURON-1, addr=NUM_WEIGHT-1): next state READY, loaded=1, load_ready=0 on the following cycle.
  - stream_start is ignored.
- READY:
  - load_valid is ignored (load_ready=0).
  - stream_start=1: at that edge, read address 0 for all channels. Next state STREAM.
- STREAM:
  - Registered read, 1-cycle latency: w_valid=1 and w_addr=0 appear in the cycle after stream_start was sampled.
  - Each edge with stream_stall=0 advances the read address by 1.
  - stream_stall=1 holds w_out, w_addr, w_valid, w_first, w_last and the read address; no read is issued.
  - At the edge where w_last is presented and stream_stall=0:
    - If stream_start=1: restart at address 0 with no bubble; w_valid stays 1.
    - Otherwise: w_valid=0 next cycle and next state READY.
  - stream_start during a non-final beat is ignored.
- load_clear: highest priority after rst, effective in any state.
  - Next state EMPTY, loaded=0, w_valid=0, write counters=0.
  - Memory contents are not erased; they are overwritten by the next load.
- Simultaneous load_clear and load_valid: load_clear wins and the beat is not written.
- rst asserted mid-load or mid-stream: same as the reset values above; a partial load must be redone.
- Arithmetic: counters are unsigned and never exceed NUM_WEIGHT-1 / NUM_NEURON-1. No weight arithmetic is performed; data passes through bit-exact.

Decomposition:
- Shared package fnn_pkg holds:
  - typedef weight_t (logic signed [DATA_WIDTH-1:0]).
  - The state enum wm_state_e {EMPTY, READY, STREAM}.
  - Default constants: WEIGHT_WIDTH=16, layer sizes.
- One natural sub-module: weight_ram_1r1w, a single-channel simple dual-port RAM (depth NUM_WEIGHT, registered read with read enable, write enable), instantiated NUM_NEURON times by a generate loop.
- The top level holds the FSM, write counters and read counter.

Test Plan:
- Reset, then load NUM_NEURON=2, NUM_WEIGHT=4, data 16'h0001..16'h0008 with no gaps -> load_ready falls after beat 8, loaded=1. Stream: w_out = {16'h0005,16'h0001},{0006,0002},{0007,0003},{0008,0004}; w_first on beat 0, w_last on beat 3, w_valid for exactly 4 cycles.
- Same load with load_valid toggled every other cycle, then a stream -> identical output; only handshaken beats are written.
- Stream with stream_stall=1 for 3 cycles while w_addr=1 -> w_out holds {0006,0002} and w_addr=1 for those cycles; total w_valid time is 7 cycles.
- stream_start held high through w_last -> second pass begins at w_addr=0 on the next cycle with no w_valid gap. Then start=0 -> state READY, busy=0.
- load_clear at w_addr=2 during a stream -> w_valid=0 next cycle, loaded=0, load_ready=1. Reload with 16'hFFF0..16'hFFF7 and stream -> first vector {FFF4,FFF0}.
- rst after 5 of 8 load beats -> loaded=0 and counters restart. A full 8-beat reload then streams correctly; stream_start issued during EMPTY produces no w_valid.
